// File: rtl/window_extremum_tracker_pkg.sv
// Shared types and constants for the window extremum tracker.
package window_extremum_tracker_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

    // Cascade inputs that make a lone comparator report plain equality
    localparam logic CASC_L = 1'b0;
    localparam logic CASC_E = 1'b1;
    localparam logic CASC_G = 1'b0;

endpackage

// File: rtl/window_extremum_tracker_cmp.sv
// Cascadable 8-bit magnitude comparator; cascade inputs decide only when a == b.
module eight_bit_comparator (
    output logic       l,
    output logic       e,
    output logic       g,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       lin,
    input  logic       ein,
    input  logic       gin
);

    // Magnitude decision with cascade fall-through on equality
    always_comb begin
        l = 1'b0;
        e = 1'b0;
        g = 1'b0;
        if (a > b) begin
            g = 1'b1;
        end else if (a < b) begin
            l = 1'b1;
        end else begin
            l = lin;
            e = ein;
            g = gin;
        end
    end

endmodule

// File: rtl/window_extremum_tracker.sv
// Tracks max/min (with first-occurrence index) over fixed windows of samples
// and holds each window result until the consumer acknowledges it.
module window_extremum_tracker
    import window_extremum_tracker_pkg::*;
#(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             res_valid,
    output logic [7:0]       res_max,
    output logic [7:0]       res_min,
    output logic [CNT_W-1:0] res_max_idx,
    output logic [CNT_W-1:0] res_min_idx,
    input  logic             res_ack
);

    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(WINDOW - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       max_q, max_d, min_q, min_d;
    logic [CNT_W-1:0] max_idx_q, max_idx_d, min_idx_q, min_idx_d;
    logic             res_valid_q, res_valid_d;
    logic [7:0]       res_max_q, res_max_d, res_min_q, res_min_d;
    logic [CNT_W-1:0] res_max_idx_q, res_max_idx_d, res_min_idx_q, res_min_idx_d;

    logic a_l_s, a_e_s, a_g_s, b_l_s, b_e_s, b_g_s;
    logic accept_s, load_s, new_max_s, new_min_s;

    eight_bit_comparator u_cmp_max (a_l_s, a_e_s, a_g_s, in_data, max_q, CASC_L, CASC_E, CASC_G);
    eight_bit_comparator u_cmp_min (b_l_s, b_e_s, b_g_s, in_data, min_q, CASC_L, CASC_E, CASC_G);

    assign in_ready  = rst_n && (state_q != ST_REPORT);
    assign accept_s  = in_valid && in_ready;
    // Outputs are one-hot; requiring exclusivity keeps ties on the stored extremum
    assign new_max_s = a_g_s && !a_e_s && !a_l_s;
    assign new_min_s = b_l_s && !b_e_s && !b_g_s;

    // Next-state, tracking and result-load logic
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        max_d         = max_q;
        min_d         = min_q;
        max_idx_d     = max_idx_q;
        min_idx_d     = min_idx_q;
        res_valid_d   = res_valid_q;
        load_s        = 1'b0;
        if (clear) begin
            state_d     = ST_EMPTY;
            count_d     = {CNT_W{1'b0}};
            res_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        max_d     = in_data;
                        min_d     = in_data;
                        max_idx_d = {CNT_W{1'b0}};
                        min_idx_d = {CNT_W{1'b0}};
                        count_d   = CNT_W'(1);
                        if (LAST_C == {CNT_W{1'b0}}) begin
                            state_d = ST_REPORT;
                            load_s  = 1'b1;
                        end else begin
                            state_d = ST_ACCUM;
                        end
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ACCUM: begin
                    if (accept_s) begin
                        if (new_max_s) begin
                            max_d     = in_data;
                            max_idx_d = count_q;
                        end else begin
                            max_d = max_q;
                        end
                        if (new_min_s) begin
                            min_d     = in_data;
                            min_idx_d = count_q;
                        end else begin
                            min_d = min_q;
                        end
                        count_d = count_q + CNT_W'(1);
                        if (count_q == LAST_C) begin
                            state_d = ST_REPORT;
                            load_s  = 1'b1;
                        end else begin
                            state_d = ST_ACCUM;
                        end
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
                ST_REPORT: begin
                    if (res_ack) begin
                        res_valid_d = 1'b0;
                        count_d     = {CNT_W{1'b0}};
                        state_d     = ST_EMPTY;
                    end else begin
                        state_d = ST_REPORT;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    count_d     = {CNT_W{1'b0}};
                    res_valid_d = 1'b0;
                end
            endcase
        end

        res_max_d     = res_max_q;
        res_min_d     = res_min_q;
        res_max_idx_d = res_max_idx_q;
        res_min_idx_d = res_min_idx_q;
        // Results capture the post-update tracking values so the final sample counts
        if (load_s) begin
            res_valid_d   = 1'b1;
            res_max_d     = max_d;
            res_min_d     = min_d;
            res_max_idx_d = max_idx_d;
            res_min_idx_d = min_idx_d;
        end else begin
            res_valid_d   = res_valid_d;
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_EMPTY;
            count_q       <= {CNT_W{1'b0}};
            max_q         <= 8'd0;
            min_q         <= 8'd0;
            max_idx_q     <= {CNT_W{1'b0}};
            min_idx_q     <= {CNT_W{1'b0}};
            res_valid_q   <= 1'b0;
            res_max_q     <= 8'd0;
            res_min_q     <= 8'd0;
            res_max_idx_q <= {CNT_W{1'b0}};
            res_min_idx_q <= {CNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            max_q         <= max_d;
            min_q         <= min_d;
            max_idx_q     <= max_idx_d;
            min_idx_q     <= min_idx_d;
            res_valid_q   <= res_valid_d;
            res_max_q     <= res_max_d;
            res_min_q     <= res_min_d;
            res_max_idx_q <= res_max_idx_d;
            res_min_idx_q <= res_min_idx_d;
        end
    end

    assign res_valid   = res_valid_q;
    assign res_max     = res_max_q;
    assign res_min     = res_min_q;
    assign res_max_idx = res_max_idx_q;
    assign res_min_idx = res_min_idx_q;

endmodule
